sw_slave: RTL

Read-only responder on the serial system bus: when the bus master issues a read addressed to this slave, the block serializes a buffered parallel value from a local source (switch bank, sensor, counter) onto `data_bus_serial` and holds `slave_busy` for the duration of the reply. It is the transmit-direction counterpart of the bus-to-display slave: same frame format and tri-state rules, data flowing slave-to-master. It sits between a local parallel source and the shared bus pins.

---
 rtl/sw_slave.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sw_slave.sv
// Read-only serial-bus slave: answers matching read frames by shifting out a buffered parallel value.
// Optional macro SW_SLAVE_PARITY_EN appends one even-parity bit to every reply.
module sw_slave #(
    parameter int         ADDRESS_WIDTH = 15,
    parameter int         DATA_WIDTH    = 8,
    parameter logic [1:0] SELF_ID       = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_util,
    inout  wire                   data_bus_serial,
    inout  wire                   slave_busy,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  read_ack
);

    localparam int MAXW = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RW,
        TURN,
        TX,
`ifdef SW_SLAVE_PARITY_EN
        PAR,
`endif
        DONE,
        WAIT
    } state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_sr;
    logic [DATA_WIDTH-1:0]    buffer;
    logic [DATA_WIDTH-1:0]    shift_sr;
    logic                     tx_oe;
    logic                     tx_bit;
    logic                     busy;
`ifdef SW_SLAVE_PARITY_EN
    logic                     par_bit;
`endif

    // Pins are driven only from registered enables, never from bus inputs directly.
    assign data_bus_serial = tx_oe ? tx_bit : 1'bz;
    assign slave_busy      = busy  ? 1'b1   : 1'bz;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus_util) begin
                    state_nxt = ADDR;
                    cnt_nxt   = CW'(1);
                end
            end
            ADDR: begin
                if (!bus_util) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(ADDRESS_WIDTH - 1)) state_nxt = RW;
                end
            end
            RW: begin
                if (!bus_util)
                    state_nxt = IDLE;
                else if (addr_sr[ADDRESS_WIDTH-1 -: 2] == SELF_ID && data_bus_serial == 1'b1)
                    state_nxt = TURN;
                else
                    state_nxt = WAIT;
            end
            TURN: begin
                if (!bus_util) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = TX;
                    cnt_nxt   = '0;
                end
            end
            TX: begin
                if (!bus_util) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
`ifdef SW_SLAVE_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
`ifdef SW_SLAVE_PARITY_EN
            PAR:  state_nxt = bus_util ? DONE : IDLE;
`endif
            DONE: state_nxt = bus_util ? WAIT : IDLE;
            WAIT: if (!bus_util) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_sr  <= '0;
            buffer   <= '0;
            shift_sr <= '0;
            tx_oe    <= 1'b0;
            tx_bit   <= 1'b0;
            busy     <= 1'b0;
            read_ack <= 1'b0;
`ifdef SW_SLAVE_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (din_valid) buffer <= din;
            if ((state == IDLE && bus_util) || state == ADDR)
                addr_sr <= {addr_sr[ADDRESS_WIDTH-2:0], data_bus_serial};
            // Snapshot uses the pre-update buffer, so a same-cycle din_valid lands in the next reply.
            if (state == RW && state_nxt == TURN) begin
                shift_sr <= buffer;
`ifdef SW_SLAVE_PARITY_EN
                par_bit  <= ^buffer;
`endif
            end
            if (state_nxt == TX) begin
                tx_bit   <= shift_sr[DATA_WIDTH-1];
                shift_sr <= shift_sr << 1;
            end
`ifdef SW_SLAVE_PARITY_EN
            if (state_nxt == PAR) tx_bit <= par_bit;
            tx_oe <= (state_nxt == TX) || (state_nxt == PAR);
            busy  <= (state_nxt == TURN) || (state_nxt == TX) || (state_nxt == PAR);
`else
            tx_oe <= (state_nxt == TX);
            busy  <= (state_nxt == TURN) || (state_nxt == TX);
`endif
            read_ack <= (state_nxt == DONE);
        end
    end

endmodule
